// File: rtl/lock_pkg.sv
// Shared types and sizing helpers for the serial-key locking controller.
package lock_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StArmed,
        StLockout
    } lock_state_e;

    function automatic int unsigned key_width(input int unsigned dw, input int unsigned ow);
        return dw + ow + 4;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned kw);
        return $clog2(kw + 1);
    endfunction

    localparam int unsigned DEF_DW   = 36;
    localparam int unsigned DEF_OW   = 7;
    localparam int unsigned KW       = key_width(DEF_DW, DEF_OW);
    localparam int unsigned MUX_BASE = DEF_DW + DEF_OW;
    localparam int unsigned CNT_W    = cnt_width(KW);

endpackage

// File: rtl/key_shift_loader.sv
// Serial key shadow register with bit counter, ready generation and commit decode.
module key_shift_loader #(
    parameter int unsigned KW    = 47,
    parameter int unsigned CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_locked,
    input  logic          i_key_valid,
    input  logic          i_key_bit,
    input  logic          i_key_commit,
    output logic          o_ready,
    output logic          o_accept,
    output logic [KW-1:0] o_shadow,
    output logic          o_commit_ok,
    output logic          o_commit_fail
);

    localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(KW);

    logic [KW-1:0]    r_shadow;
    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    // Commit takes priority: a bit offered alongside a commit is never accepted.
    always_comb begin
        w_full        = (r_cnt == LP_FULL);
        o_ready       = !i_locked && (r_cnt < LP_FULL) && !i_key_commit;
        o_accept      = i_key_valid && o_ready;
        o_commit_ok   = !i_locked && i_key_commit && w_full;
        o_commit_fail = !i_locked && i_key_commit && !w_full;
        o_shadow      = r_shadow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else if (o_commit_ok || o_commit_fail) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else if (o_accept) begin
            r_shadow <= {i_key_bit, r_shadow[KW-1:1]};
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lock_key_controller.sv
// Key-locked pad interface: serial key load, XOR-locked in/out buses, MUX key table,
// failed-commit counter with permanent lockout.
module lock_key_controller
    import lock_pkg::*;
#(
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned OW       = DEF_OW,
    parameter int unsigned MAX_FAIL = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_in_valid,
    input  logic          key_in_bit,
    output logic          key_in_ready,
    input  logic          key_commit,
    output logic          key_armed,
    output logic          lockout,
    output logic [2:0]    fail_cnt,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic [DW-1:0] core_din,
    output logic          core_din_valid,
    input  logic [OW-1:0] core_dout,
    input  logic          core_dout_valid,
    output logic [OW-1:0] dout,
    output logic          dout_valid,
    input  logic [1:0]    mux_s,
    output logic          mux_o
);

    localparam int unsigned LP_KW       = key_width(DW, OW);
    localparam int unsigned LP_MUX_BASE = DW + OW;
    localparam int unsigned LP_CNT_W    = cnt_width(LP_KW);
    localparam logic [2:0]  LP_MAX_FAIL = 3'(MAX_FAIL);

    lock_state_e      r_state;
    lock_state_e      w_state_next;
    logic [LP_KW-1:0] r_key;
    logic [LP_KW-1:0] w_shadow;
    logic             r_armed;
    logic [2:0]       r_fail_cnt;
    logic [DW-1:0]    r_core_din;
    logic             r_core_din_valid;
    logic [OW-1:0]    r_dout;
    logic             r_dout_valid;
    logic             w_locked;
    logic             w_accept;
    logic             w_commit_ok;
    logic             w_commit_fail;
    logic             w_fail_hit;
    logic             w_lock_entry;
    logic [3:0]       w_mux_keys;

    key_shift_loader #(
        .KW    (LP_KW),
        .CNT_W (LP_CNT_W)
    ) u_loader (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_locked      (w_locked),
        .i_key_valid   (key_in_valid),
        .i_key_bit     (key_in_bit),
        .i_key_commit  (key_commit),
        .o_ready       (key_in_ready),
        .o_accept      (w_accept),
        .o_shadow      (w_shadow),
        .o_commit_ok   (w_commit_ok),
        .o_commit_fail (w_commit_fail)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_locked     = (r_state == StLockout);
        w_fail_hit   = ((r_fail_cnt + 3'd1) == LP_MAX_FAIL);
        w_lock_entry = w_commit_fail && w_fail_hit;
        w_state_next = r_state;
        case (r_state)
            StLockout: w_state_next = StLockout;
            default: begin
                if (w_commit_fail) begin
                    if (w_fail_hit) begin
                        w_state_next = StLockout;
                    end else begin
                        w_state_next = r_armed ? StArmed : StIdle;
                    end
                end else if (w_commit_ok) begin
                    w_state_next = StArmed;
                end else if (w_accept) begin
                    w_state_next = StLoad;
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        lockout        = (r_state == StLockout);
        key_armed      = r_armed;
        fail_cnt       = r_fail_cnt;
        core_din       = r_core_din;
        core_din_valid = r_core_din_valid;
        dout           = r_dout;
        dout_valid     = r_dout_valid;
        w_mux_keys     = r_key[LP_KW-1:LP_MUX_BASE];
        mux_o          = w_mux_keys[mux_s];
    end

    // Lockout zeroes the key so the datapath degrades to plain pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key      <= '0;
            r_armed    <= 1'b0;
            r_fail_cnt <= '0;
        end else begin
            if (w_commit_fail) begin
                r_fail_cnt <= r_fail_cnt + 3'd1;
            end
            if (w_lock_entry) begin
                r_key   <= '0;
                r_armed <= 1'b0;
            end else if (w_commit_ok) begin
                r_key   <= w_shadow;
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_din       <= '0;
            r_core_din_valid <= 1'b0;
            r_dout           <= '0;
            r_dout_valid     <= 1'b0;
        end else begin
            r_core_din       <= din ^ r_key[DW-1:0];
            r_core_din_valid <= din_valid;
            r_dout           <= core_dout ^ r_key[DW+OW-1:DW];
            r_dout_valid     <= core_dout_valid;
        end
    end

endmodule

// File: tb/tb_lock_key_controller.sv
// Scoreboard bench for lock_key_controller with a behavioural key/lockout model.
module tb_lock_key_controller;
    import lock_pkg::*;

    typedef struct {
        logic [35:0] din;
        logic        din_valid;
        logic [6:0]  dout;
        logic        dout_valid;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        key_in_valid;
    logic        key_in_bit;
    logic        key_in_ready;
    logic        key_commit;
    logic        key_armed;
    logic        lockout;
    logic [2:0]  fail_cnt;
    logic [35:0] din;
    logic        din_valid;
    logic [35:0] core_din;
    logic        core_din_valid;
    logic [6:0]  core_dout;
    logic        core_dout_valid;
    logic [6:0]  dout;
    logic        dout_valid;
    logic [1:0]  mux_s;
    logic        mux_o;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t        sb[$];
    logic [46:0] m_key;
    logic [46:0] m_shadow;
    int          m_cnt;
    int          m_fail;
    logic        m_armed;
    logic        m_lock;

    lock_key_controller #(
        .DW       (36),
        .OW       (7),
        .MAX_FAIL (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_in_valid    (key_in_valid),
        .key_in_bit      (key_in_bit),
        .key_in_ready    (key_in_ready),
        .key_commit      (key_commit),
        .key_armed       (key_armed),
        .lockout         (lockout),
        .fail_cnt        (fail_cnt),
        .din             (din),
        .din_valid       (din_valid),
        .core_din        (core_din),
        .core_din_valid  (core_din_valid),
        .core_dout       (core_dout),
        .core_dout_valid (core_dout_valid),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .mux_s           (mux_s),
        .mux_o           (mux_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key    = '0;
        m_shadow = '0;
        m_cnt    = 0;
        m_fail   = 0;
        m_armed  = 1'b0;
        m_lock   = 1'b0;
        sb.delete();
    endtask

    task automatic drive_data(input bit fv);
        din             = 36'({$urandom(), $urandom()});
        core_dout       = 7'($urandom());
        mux_s           = 2'($urandom());
        din_valid       = fv ? 1'b1 : 1'($urandom());
        core_dout_valid = fv ? 1'b1 : 1'($urandom());
    endtask

    // One clock: check combinational outputs, push expectations, advance model, pop and compare.
    task automatic step();
        exp_t e;
        logic rdy;
        #1;
        rdy = !m_lock && (m_cnt < KW) && !key_commit;
        check("key_in_ready", 64'(key_in_ready), 64'(rdy));
        check("mux_o", 64'(mux_o), 64'(m_key[MUX_BASE + 32'(mux_s)]));
        e.din        = din ^ m_key[35:0];
        e.din_valid  = din_valid;
        e.dout       = core_dout ^ m_key[42:36];
        e.dout_valid = core_dout_valid;
        sb.push_back(e);
        if (!m_lock) begin
            if (key_commit) begin
                if (m_cnt == KW) begin
                    m_key   = m_shadow;
                    m_armed = 1'b1;
                end else begin
                    m_fail++;
                    if (m_fail == 3) begin
                        m_lock  = 1'b1;
                        m_key   = '0;
                        m_armed = 1'b0;
                    end
                end
                m_shadow = '0;
                m_cnt    = 0;
            end else if (key_in_valid && rdy) begin
                m_shadow = {key_in_bit, m_shadow[46:1]};
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("core_din", 64'(core_din), 64'(e.din));
        check("core_din_valid", 64'(core_din_valid), 64'(e.din_valid));
        check("dout", 64'(dout), 64'(e.dout));
        check("dout_valid", 64'(dout_valid), 64'(e.dout_valid));
        check("key_armed", 64'(key_armed), 64'(m_armed));
        check("lockout", 64'(lockout), 64'(m_lock));
        check("fail_cnt", 64'(fail_cnt), 64'(m_fail));
    endtask

    task automatic shift_bit(input logic b, input bit fv);
        drive_data(fv);
        key_in_valid = 1'b1;
        key_in_bit   = b;
        key_commit   = 1'b0;
        step();
    endtask

    task automatic commit(input logic with_bit);
        drive_data(1'b0);
        key_in_valid = with_bit;
        key_in_bit   = 1'b1;
        key_commit   = 1'b1;
        step();
        key_commit   = 1'b0;
        key_in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        key_in_valid = 1'b0;
        key_in_bit   = 1'b0;
        key_commit   = 1'b0;
        din          = '0;
        din_valid    = 1'b0;
        core_dout    = '0;
        core_dout_valid = 1'b0;
        mux_s        = 2'd0;
        model_reset();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        key_in_valid = 1'b0;
        key_in_bit = 1'b0;
        key_commit = 1'b0;
        din = '0;
        din_valid = 1'b0;
        core_dout = '0;
        core_dout_valid = 1'b0;
        mux_s = 2'd0;
        model_reset();
        #3;
        check("rst_key_in_ready", 64'(key_in_ready), 64'd1);
        check("rst_key_armed", 64'(key_armed), 64'd0);
        check("rst_lockout", 64'(lockout), 64'd0);
        check("rst_fail_cnt", 64'(fail_cnt), 64'd0);
        check("rst_core_din_valid", 64'(core_din_valid), 64'd0);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through before any key.
        din = 36'hFFFFFFFFF;
        din_valid = 1'b1;
        step();
        check("passthru_core_din", 64'(core_din), 64'h0_FFFF_FFFF_F);

        // Alternating key, bit i = i%2.
        for (int i = 0; i < 47; i++) shift_bit(1'(i % 2), 1'b0);
        commit(1'b0);
        check("armed_after_commit", 64'(key_armed), 64'd1);
        din = '0;
        core_dout = '0;
        din_valid = 1'b1;
        core_dout_valid = 1'b1;
        mux_s = 2'd0;
        #1;
        check("mux_s0", 64'(mux_o), 64'd1);
        mux_s = 2'd3;
        #1;
        check("mux_s3", 64'(mux_o), 64'd0);
        step();
        check("keyed_core_din", 64'(core_din), 64'h0_AAAA_AAAA_A);

        // Short load while armed: fail, old key stays active.
        for (int i = 0; i < 10; i++) shift_bit(1'($urandom()), 1'b0);
        commit(1'b0);
        check("fail_cnt_one", 64'(fail_cnt), 64'd1);
        check("still_armed", 64'(key_armed), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive_data(1'b0);
            step();
        end

        // Full shadow refuses the 48th bit; commit with a bit alongside switches keys.
        for (int i = 0; i < 47; i++) shift_bit(1'($urandom()), 1'b0);
        drive_data(1'b0);
        key_in_valid = 1'b1;
        #1;
        check("ready_when_full", 64'(key_in_ready), 64'd0);
        step();
        commit(1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_data(1'b1);
            step();
        end

        // Three failed commits from reset lock the block permanently.
        apply_reset();
        for (int i = 0; i < 3; i++) commit(1'b0);
        check("lockout_set", 64'(lockout), 64'd1);
        for (int i = 0; i < 8; i++) begin
            drive_data(1'b0);
            key_in_valid = 1'($urandom());
            key_in_bit   = 1'($urandom());
            key_commit   = 1'($urandom());
            step();
        end
        key_commit = 1'b0;
        check("lockout_held", 64'(lockout), 64'd1);

        // Asynchronous reset in the middle of a load.
        apply_reset();
        for (int i = 0; i < 20; i++) shift_bit(1'($urandom()), 1'b1);
        check("pre_reset_valid", 64'(core_din_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_core_din_valid", 64'(core_din_valid), 64'd0);
        check("async_dout_valid", 64'(dout_valid), 64'd0);
        check("async_core_din", 64'(core_din), 64'd0);
        check("async_key_in_ready", 64'(key_in_ready), 64'd1);
        model_reset();
        key_in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        commit(1'b0);
        check("fail_after_reset", 64'(fail_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
